// File: rtl/midi_uart_if.sv
// MIDI UART host/line signal bundle: the host drives writes, reads and error
// clears; the serial lines travel with the bundle.
interface midi_uart_if;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_full;
  logic       tx_idle;
  logic       midi_tx;
  logic       midi_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_rd;
  logic       rx_overrun;
  logic       rx_ferr;
  logic       err_clr;

  modport master (
    output tx_data, tx_wr, midi_rx, rx_rd, err_clr,
    input  tx_full, tx_idle, midi_tx, rx_data, rx_valid, rx_overrun, rx_ferr
  );

  modport slave (
    input  tx_data, tx_wr, midi_rx, rx_rd, err_clr,
    output tx_full, tx_idle, midi_tx, rx_data, rx_valid, rx_overrun, rx_ferr
  );
endinterface

// File: rtl/midi_uart.sv
// MIDI UART: 16-deep TX FIFO feeding an 8N1 serializer, and an 8N1 receiver
// with a single holding register plus sticky overrun/framing flags.
module midi_uart #(
  parameter int CLK_HZ = 24576000,
  parameter int BAUD   = 31250
) (
  input  logic        CLK_AUDIO,
  input  logic        reset,
  midi_uart_if.slave  bus
);
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int TW  = $clog2(DIV);
  localparam logic [TW-1:0] BIT_T  = TW'(DIV - 1);
  localparam logic [TW-1:0] HALF_T = TW'(DIV / 2 - 1);
  localparam logic [TW-1:0] T_ZERO = TW'(0);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;

  logic [7:0] mem_q [16];
  logic [3:0] wp_q, rp_q;
  logic [4:0] cnt_q, cnt_d;
  logic       tx_push, tx_pop;
  logic       tx_full_q, tx_full_d, tx_idle_q, tx_idle_d;

  tx_state_t  tx_state_q, tx_state_d;
  logic [TW-1:0] tx_tmr_q, tx_tmr_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       midi_tx_q, midi_tx_d;

  logic [1:0] sync_q;
  logic       rx_prev_q, rx_line;
  rx_state_t  rx_state_q, rx_state_d;
  logic [TW-1:0] rx_tmr_q, rx_tmr_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;
  logic       deliver, ovr_set, ferr_set;

  // A write against a full FIFO is dropped even when a pop frees a slot this cycle.
  assign tx_push = bus.tx_wr && !tx_full_q;
  assign rx_line = sync_q[1];

  // TX serializer next state: pops the FIFO from IDLE or straight out of STOP.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tmr_d   = tx_tmr_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    midi_tx_d  = midi_tx_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        midi_tx_d = 1'b1;
        if (cnt_q != 5'd0) begin
          tx_pop     = 1'b1;
          tx_sh_d    = mem_q[rp_q];
          tx_tmr_d   = BIT_T;
          tx_state_d = TX_START;
          midi_tx_d  = 1'b0;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_tmr_q == T_ZERO) begin
          tx_state_d = TX_DATA;
          tx_tmr_d   = BIT_T;
          tx_bit_d   = 3'd0;
          midi_tx_d  = tx_sh_q[0];
        end else begin
          tx_tmr_d = tx_tmr_q - T_ONE;
        end
      end
      TX_DATA: begin
        if (tx_tmr_q == T_ZERO) begin
          tx_tmr_d = BIT_T;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            midi_tx_d  = 1'b1;
          end else begin
            tx_bit_d  = tx_bit_q + 3'd1;
            tx_sh_d   = {1'b0, tx_sh_q[7:1]};
            midi_tx_d = tx_sh_q[1];
          end
        end else begin
          tx_tmr_d = tx_tmr_q - T_ONE;
        end
      end
      TX_STOP: begin
        if (tx_tmr_q == T_ZERO) begin
          if (cnt_q != 5'd0) begin
            tx_pop     = 1'b1;
            tx_sh_d    = mem_q[rp_q];
            tx_tmr_d   = BIT_T;
            tx_state_d = TX_START;
            midi_tx_d  = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
            midi_tx_d  = 1'b1;
          end
        end else begin
          tx_tmr_d = tx_tmr_q - T_ONE;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        midi_tx_d  = 1'b1;
      end
    endcase
    cnt_d     = cnt_q + 5'(tx_push) - 5'(tx_pop);
    tx_full_d = (cnt_d == 5'd16);
    tx_idle_d = (tx_state_d == TX_IDLE) && (cnt_d == 5'd0);
  end

  // TX state, FIFO storage and registered TX status outputs.
  always_ff @(posedge CLK_AUDIO or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
      wp_q       <= 4'd0;
      rp_q       <= 4'd0;
      cnt_q      <= 5'd0;
      tx_full_q  <= 1'b0;
      tx_idle_q  <= 1'b1;
      tx_state_q <= TX_IDLE;
      tx_tmr_q   <= T_ONE;
      tx_bit_q   <= 3'd0;
      tx_sh_q    <= 8'hFF;
      midi_tx_q  <= 1'b1;
    end else begin
      if (tx_push) begin
        mem_q[wp_q] <= bus.tx_data;
        wp_q        <= wp_q + 4'd1;
      end
      if (tx_pop) rp_q <= rp_q + 4'd1;
      cnt_q      <= cnt_d;
      tx_full_q  <= tx_full_d;
      tx_idle_q  <= tx_idle_d;
      tx_state_q <= tx_state_d;
      tx_tmr_q   <= tx_tmr_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      midi_tx_q  <= midi_tx_d;
    end
  end

  // RX deframer: start bit re-checked at its centre, then one sample per bit centre.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tmr_d   = rx_tmr_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    deliver    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state_q)
      RX_HUNT: begin
        if (rx_prev_q && !rx_line) begin
          rx_state_d = RX_START;
          rx_tmr_d   = HALF_T;
        end else begin
          rx_state_d = RX_HUNT;
        end
      end
      RX_START: begin
        if (rx_tmr_q == T_ZERO) begin
          if (!rx_line) begin
            rx_state_d = RX_DATA;
            rx_tmr_d   = BIT_T;
            rx_bit_d   = 3'd0;
          end else begin
            rx_state_d = RX_HUNT;
          end
        end else begin
          rx_tmr_d = rx_tmr_q - T_ONE;
        end
      end
      RX_DATA: begin
        if (rx_tmr_q == T_ZERO) begin
          rx_sh_d  = {rx_line, rx_sh_q[7:1]};
          rx_tmr_d = BIT_T;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_tmr_d = rx_tmr_q - T_ONE;
        end
      end
      RX_STOP: begin
        if (rx_tmr_q == T_ZERO) begin
          if (rx_line) begin
            deliver    = 1'b1;
            rx_state_d = RX_HUNT;
          end else begin
            ferr_set   = 1'b1;
            rx_state_d = RX_WAITHI;
          end
        end else begin
          rx_tmr_d = rx_tmr_q - T_ONE;
        end
      end
      RX_WAITHI: begin
        if (rx_line) rx_state_d = RX_HUNT;
        else         rx_state_d = RX_WAITHI;
      end
      default: rx_state_d = RX_HUNT;
    endcase

    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ovr_set    = 1'b0;
    if (deliver) begin
      if (!rx_valid_q || bus.rx_rd) begin
        rx_data_d  = rx_sh_q;
        rx_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (bus.rx_rd) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
    // Setting wins over a same-cycle clear.
    rx_ovr_d  = ovr_set  || (rx_ovr_q  && !bus.err_clr);
    rx_ferr_d = ferr_set || (rx_ferr_q && !bus.err_clr);
  end

  // RX synchronizer, deframer state and registered RX outputs.
  always_ff @(posedge CLK_AUDIO or posedge reset) begin
    if (reset) begin
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_HUNT;
      rx_tmr_q   <= T_ONE;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], bus.midi_rx};
      rx_prev_q  <= rx_line;
      rx_state_q <= rx_state_d;
      rx_tmr_q   <= rx_tmr_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign bus.midi_tx    = midi_tx_q;
  assign bus.tx_full    = tx_full_q;
  assign bus.tx_idle    = tx_idle_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_overrun = rx_ovr_q;
  assign bus.rx_ferr    = rx_ferr_q;
endmodule

// File: tb/tb_midi_uart.sv
// Directed bench for midi_uart at DIV=100: TX waveform, FIFO full/drop,
// loopback receive, overrun, glitch rejection, framing error, mid-frame reset.
module tb_midi_uart;
  localparam int CLK_HZ = 3125000;
  localparam int BAUD   = 31250;
  localparam int DIV    = 100;

  logic clk = 1'b0;
  logic rst;
  logic loop_en;
  logic rx_drv;

  always #5 clk = ~clk;

  midi_uart_if bus ();
  assign bus.midi_rx = loop_en ? bus.midi_tx : rx_drv;

  midi_uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .CLK_AUDIO(clk),
    .reset(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level at offset 0..999 within a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int off);
    int j;
    j = off / DIV;
    if (j == 0)      return 1'b0;
    else if (j <= 8) return b[j-1];
    else             return 1'b1;
  endfunction

  task automatic send_rx(input logic [7:0] b, input logic stop_lvl);
    rx_drv = 1'b0;
    repeat (DIV) tick();
    for (int j = 0; j < 8; j++) begin
      rx_drv = b[j];
      repeat (DIV) tick();
    end
    rx_drv = stop_lvl;
    repeat (DIV) tick();
    rx_drv = 1'b1;
  endtask

  task automatic pulse_err_clr();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    tick();
  endtask

  task automatic pulse_rx_rd();
    bus.rx_rd = 1'b1;
    tick();
    bus.rx_rd = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] wbytes [17];
    logic [7:0] frames [17];
    logic       exp;
    int         bad;
    int         first;

    rst         = 1'b1;
    loop_en     = 1'b0;
    rx_drv      = 1'b1;
    bus.tx_data = 8'h00;
    bus.tx_wr   = 1'b0;
    bus.rx_rd   = 1'b0;
    bus.err_clr = 1'b0;
    #12;
    check("rst_midi_tx", 32'(bus.midi_tx), 32'd1);
    check("rst_tx_full", 32'(bus.tx_full), 32'd0);
    check("rst_tx_idle", 32'(bus.tx_idle), 32'd1);
    check("rst_rx_data", 32'(bus.rx_data), 32'h00);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_overrun", 32'(bus.rx_overrun), 32'd0);
    check("rst_rx_ferr", 32'(bus.rx_ferr), 32'd0);
    #11 rst = 1'b0;
    repeat (5) tick();

    // Single frame 0x90, write in cycle 0.
    bus.tx_data = 8'h90;
    bus.tx_wr   = 1'b1;
    bad = 0;
    for (int cyc = 1; cyc <= 1002; cyc++) begin
      tick();
      bus.tx_wr = 1'b0;
      exp = (cyc < 2) ? 1'b1 : ((cyc < 1002) ? frame_bit(8'h90, cyc - 2) : 1'b1);
      if (bus.midi_tx !== exp) bad++;
      if (cyc == 1)    check("tx_c1_high", 32'(bus.midi_tx), 32'd1);
      if (cyc == 2)    check("tx_c2_start", 32'(bus.midi_tx), 32'd0);
      if (cyc == 1001) check("tx_idle_c1001", 32'(bus.tx_idle), 32'd0);
      if (cyc == 1002) check("tx_idle_c1002", 32'(bus.tx_idle), 32'd1);
    end
    check("tx_wave_90", 32'(bad), 32'd0);
    repeat (10) tick();

    // 1 byte + 17 back-to-back writes while busy: 16 accepted, 17th dropped.
    for (int i = 0; i < 17; i++) wbytes[i] = 8'(i * 37 + 3);
    frames[0] = 8'hA5;
    for (int i = 1; i < 17; i++) frames[i] = wbytes[i-1];
    bus.tx_data = 8'hA5;
    bus.tx_wr   = 1'b1;
    bad = 0;
    for (int cyc = 1; cyc <= 17010; cyc++) begin
      tick();
      if (cyc < 2) exp = 1'b1;
      else if ((cyc - 2) / 1000 < 17) exp = frame_bit(frames[(cyc - 2) / 1000], (cyc - 2) % 1000);
      else exp = 1'b1;
      if (bus.midi_tx !== exp) bad++;
      if (cyc == 20)    check("tx_full_c20", 32'(bus.tx_full), 32'd0);
      if (cyc == 21)    check("tx_full_c21", 32'(bus.tx_full), 32'd1);
      if (cyc == 17001) check("tx_idle_end0", 32'(bus.tx_idle), 32'd0);
      if (cyc == 17002) check("tx_idle_end1", 32'(bus.tx_idle), 32'd1);
      if (cyc >= 5 && cyc <= 21) begin
        bus.tx_wr   = 1'b1;
        bus.tx_data = wbytes[cyc - 5];
      end else begin
        bus.tx_wr = 1'b0;
      end
    end
    check("tx_wave_burst", 32'(bad), 32'd0);
    check("tx_full_after", 32'(bus.tx_full), 32'd0);

    // Loopback 0x3C; stop-bit centre at cycle 952.
    loop_en     = 1'b1;
    repeat (10) tick();
    bus.tx_data = 8'h3C;
    bus.tx_wr   = 1'b1;
    first = -1;
    for (int cyc = 1; cyc <= 1100; cyc++) begin
      tick();
      bus.tx_wr = 1'b0;
      if (bus.rx_valid && first < 0) first = cyc;
    end
    check("rx_loop_latency", 32'(first >= 952 && first <= 955), 32'd1);
    check("rx_loop_data", 32'(bus.rx_data), 32'h3C);
    check("rx_loop_flags", {30'd0, bus.rx_overrun, bus.rx_ferr}, 32'd0);
    pulse_rx_rd();
    check("rx_rd_clears", 32'(bus.rx_valid), 32'd0);
    loop_en = 1'b0;
    repeat (20) tick();

    // Overrun: two frames back-to-back without a read.
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (60) tick();
    check("ovr_valid", 32'(bus.rx_valid), 32'd1);
    check("ovr_data", 32'(bus.rx_data), 32'h11);
    check("ovr_flag", 32'(bus.rx_overrun), 32'd1);
    check("ovr_no_ferr", 32'(bus.rx_ferr), 32'd0);
    pulse_err_clr();
    check("ovr_cleared", 32'(bus.rx_overrun), 32'd0);
    pulse_rx_rd();
    check("ovr_rd_valid", 32'(bus.rx_valid), 32'd0);

    // 30-cycle glitch is rejected.
    rx_drv = 1'b0;
    repeat (30) tick();
    rx_drv = 1'b1;
    repeat (200) tick();
    check("glitch_valid", 32'(bus.rx_valid), 32'd0);
    check("glitch_flags", {30'd0, bus.rx_overrun, bus.rx_ferr}, 32'd0);

    // Framing error: 0x55 with stop bit low.
    send_rx(8'h55, 1'b0);
    repeat (60) tick();
    check("ferr_flag", 32'(bus.rx_ferr), 32'd1);
    check("ferr_valid", 32'(bus.rx_valid), 32'd0);
    check("ferr_data_kept", 32'(bus.rx_data), 32'h11);
    pulse_err_clr();
    check("ferr_cleared", 32'(bus.rx_ferr), 32'd0);

    // Reset 400 cycles into a 0x00 frame: line is low in data bit 2.
    bus.tx_data = 8'h00;
    bus.tx_wr   = 1'b1;
    tick();
    bus.tx_wr = 1'b0;
    repeat (399) tick();
    check("rst_pre_low", 32'(bus.midi_tx), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_tx", 32'(bus.midi_tx), 32'd1);
    check("rst_async_idle", 32'(bus.tx_idle), 32'd1);
    #2 rst = 1'b0;
    bad = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      if (bus.midi_tx !== 1'b1) bad++;
    end
    check("rst_no_resume", 32'(bad), 32'd0);
    check("rst_idle_after", 32'(bus.tx_idle), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/midi_uart.md
MIDI_UART -- requirements
Module: midi_uart

Interface
REQ-001 Parameter CLK_HZ, default 24576000, CLK_AUDIO frequency in Hz.
REQ-002 Parameter BAUD, default 31250, MIDI bit rate; DIV = (CLK_HZ + BAUD/2) / BAUD clocks per bit (786 at defaults).
REQ-003 CLK_AUDIO  in  1  sole clock; all state on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 tx_data  in  8  byte to transmit.
REQ-006 tx_wr  in  1  one-cycle write strobe for tx_data.
REQ-007 tx_full  out  1  TX FIFO holds 16 bytes.
REQ-008 tx_idle  out  1  TX FIFO empty and serializer idle.
REQ-009 midi_tx  out  1  serial MIDI out, idle high; drives mt32pi midi_tx.
REQ-010 midi_rx  in  1  serial MIDI in, asynchronous; driven from mt32pi midi_rx.
REQ-011 rx_data  out  8  last received byte.
REQ-012 rx_valid  out  1  rx_data holds an unread byte.
REQ-013 rx_rd  in  1  one-cycle read strobe; consumes rx_data.
REQ-014 rx_overrun  out  1  sticky: byte lost because rx_valid was still set.
REQ-015 rx_ferr  out  1  sticky: stop bit sampled low.
REQ-016 err_clr  in  1  one-cycle pulse; clears rx_overrun and rx_ferr.

Function
REQ-017 TX FIFO: 16 entries, 4-bit read/write pointers wrapping 15->0, 5-bit count.
REQ-018 tx_wr with tx_full=0 writes tx_data; tx_wr with tx_full=1 is ignored, even if a pop occurs the same cycle.
REQ-019 Simultaneous write and pop on a non-full FIFO leaves count unchanged.
REQ-020 TX FSM states IDLE, START, DATA, STOP; bit timer counts DIV-1 down to 0 per bit.
REQ-021 IDLE: midi_tx=1; FIFO non-empty -> pop into shift register, go START next cycle.
REQ-022 Latency: tx_wr at cycle N into empty FIFO with IDLE FSM -> midi_tx low from cycle N+2.
REQ-023 START: midi_tx=0 for DIV cycles; DATA: 8 bits LSB first, DIV cycles each; STOP: midi_tx=1 for DIV cycles.
REQ-024 STOP end: FIFO non-empty -> next START with no extra idle cycle; else IDLE.
REQ-025 Frame = 10*DIV cycles; midi_tx registered, glitch-free.
REQ-026 midi_rx passes a 2-flop synchronizer before use.
REQ-027 RX FSM states HUNT, START, DATA, STOP, WAITHI.
REQ-028 HUNT: synchronized falling edge -> START, timer = DIV/2 - 1.
REQ-029 START: at timer 0, line low -> DATA with timer DIV-1; line high -> HUNT (glitch rejected, no flags).
REQ-030 DATA: sample at each timer 0, shift in LSB first, after 8 samples -> STOP.
REQ-031 STOP sample high: deliver byte; sample low: set rx_ferr, discard byte, go WAITHI.
REQ-032 WAITHI: remain until synchronized line is high, then HUNT.
REQ-033 Delivery with rx_valid=0, or with rx_rd the same cycle: rx_data<=byte, rx_valid=1.
REQ-034 Delivery with rx_valid=1 and no rx_rd: rx_data keeps old byte, rx_overrun set.
REQ-035 rx_rd with no delivery clears rx_valid; rx_rd while rx_valid=0 has no effect.
REQ-036 err_clr in the same cycle as a flag-setting event: flag ends set.
REQ-037 After STOP delivery the RX FSM returns to HUNT; back-to-back frames are received.

Reset
REQ-038 reset: midi_tx=1, tx_full=0, tx_idle=1, rx_data=0x00, rx_valid=0, rx_overrun=0, rx_ferr=0.
REQ-039 reset: FIFO flushed, both FSMs in IDLE/HUNT, timers and synchronizer set to 1/idle.
REQ-040 reset mid-frame: midi_tx goes high asynchronously; the partial frame is not resumed; partial RX byte is dropped.

Verification (CLK_HZ=3125000, BAUD=31250, DIV=100)
REQ-041 Write 0x90 into idle block at cycle 0 -> midi_tx low cycles 2-101; bits 0,0,0,0,1,0,0,1 over cycles 102-901; high cycles 902-1001; tx_idle=1 from cycle 1002.
REQ-042 Write 17 bytes back-to-back while the FSM is busy -> tx_full=1 after the 16th; 17th dropped; exactly 16 contiguous frames with no idle gaps.
REQ-043 Loop midi_tx to midi_rx and send 0x3C -> rx_valid=1 with rx_data=0x3C within 3 cycles after the TX stop-bit centre.
REQ-044 Receive 0x11 then 0x22 without rx_rd -> rx_data=0x11, rx_overrun=1; err_clr -> rx_overrun=0.
REQ-045 Drive a 30-cycle low pulse on midi_rx -> no rx_valid, no flags; frame 0x55 with stop bit low -> rx_ferr=1, rx_valid=0.
REQ-046 Assert reset 400 cycles into a TX frame -> midi_tx=1 at once, tx_idle=1, no further frames.
